// File: rtl/wfq_sched.sv
// Weighted fair-queue scheduler: picks the head packet with the smallest wrap-safe finish tag
// and streams it whole. Define WFQ_WEIGHT_EN to add the per-channel weight port.
module wfq_sched #(
    parameter int unsigned NUM_IN_LOG2 = 3,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned VT_W        = 32,
    localparam int unsigned N          = 2 ** NUM_IN_LOG2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           fifo_empty,
    input  logic [N*DATA_W-1:0]    fifo_data,
    output logic [N-1:0]           fifo_rdreq,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_last,
    output logic [NUM_IN_LOG2-1:0] out_chan
`ifdef WFQ_WEIGHT_EN
    ,
    input  logic [N*4-1:0]         weight
`endif
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                 state_q, state_d;
    logic [VT_W-1:0]        vtime_q, vtime_d;
    logic [VT_W-1:0]        last_finish_q [N];
    logic [NUM_IN_LOG2-1:0] cur_q, cur_d;
    logic [VT_W-1:0]        tag_q, tag_d;
    logic [LEN_W-1:0]       remaining_q, remaining_d;

    logic [DATA_W-1:0]      head [N];
    logic [LEN_W-1:0]       len  [N];
    logic [3:0]             cost [N];
    logic [LEN_W+3:0]       prod [N];
    logic [VT_W-1:0]        base [N];
    logic [VT_W-1:0]        cand [N];

    logic                   found;
    logic [NUM_IN_LOG2-1:0] pick;
    logic [VT_W-1:0]        pick_tag;
    logic                   xfer;
    logic                   last_xfer;

    // a < b when the modular difference is negative as a signed value
    function automatic logic wrap_lt(logic [VT_W-1:0] a, logic [VT_W-1:0] b);
        logic [VT_W-1:0] d;
        d = a - b;
        return d[VT_W-1];
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            head[i] = fifo_data[i*DATA_W +: DATA_W];
            len[i]  = (head[i][LEN_W-1:0] == '0) ? LEN_W'(1) : head[i][LEN_W-1:0];
`ifdef WFQ_WEIGHT_EN
            cost[i] = (weight[i*4 +: 4] == 4'd0) ? 4'd1 : weight[i*4 +: 4];
`else
            cost[i] = 4'd1;
`endif
            prod[i] = {4'd0, len[i]} * {{LEN_W{1'b0}}, cost[i]};
            base[i] = wrap_lt(vtime_q, last_finish_q[i]) ? last_finish_q[i] : vtime_q;
            cand[i] = base[i] + VT_W'(prod[i]);
        end
    end

    // Strict less-than keeps ties on the lowest index.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        pick_tag = '0;
        for (int i = 0; i < N; i++) begin
            if (!fifo_empty[i] && (!found || wrap_lt(cand[i], pick_tag))) begin
                found    = 1'b1;
                pick     = NUM_IN_LOG2'(i);
                pick_tag = cand[i];
            end
        end
    end

    assign xfer      = (state_q == StSend) && !fifo_empty[cur_q] && out_ready;
    assign last_xfer = xfer && (remaining_q == LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            vtime_q     <= '0;
            cur_q       <= '0;
            tag_q       <= '0;
            remaining_q <= '0;
            for (int i = 0; i < N; i++) begin
                last_finish_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            vtime_q     <= vtime_d;
            cur_q       <= cur_d;
            tag_q       <= tag_d;
            remaining_q <= remaining_d;
            if (last_xfer) begin
                last_finish_q[cur_q] <= tag_q;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        vtime_d     = vtime_q;
        cur_d       = cur_q;
        tag_d       = tag_q;
        remaining_d = remaining_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d     = StSend;
                    cur_d       = pick;
                    tag_d       = pick_tag;
                    remaining_d = len[pick];
                end
            end
            StSend: begin
                if (xfer) begin
                    vtime_d     = vtime_q + VT_W'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    if (last_xfer) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        out_chan   = '0;
        fifo_rdreq = '0;
        if (state_q == StSend) begin
            out_valid = !fifo_empty[cur_q];
            out_data  = head[cur_q];
            out_last  = (remaining_q == LEN_W'(1));
            out_chan  = cur_q;
            if (xfer) begin
                fifo_rdreq[cur_q] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wfq_sched.sv
// Bench for wfq_sched: FIFO models plus a tag-arithmetic reference scheduler, driven by a
// vector table, hand sequences and random traffic.
`timescale 1ns/1ps
module tb_wfq_sched;

    localparam int NL    = 2;
    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int LW    = 4;
    localparam int VW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  fifo_empty;
    logic [N*DW-1:0] fifo_data;
    logic [N-1:0]  fifo_rdreq;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [NL-1:0] out_chan;
`ifdef WFQ_WEIGHT_EN
    logic [N*4-1:0] weight;
`endif

    always #5 clk = ~clk;

    wfq_sched #(.NUM_IN_LOG2(NL), .DATA_W(DW), .LEN_W(LW), .VT_W(VW)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rdreq (fifo_rdreq),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_chan   (out_chan)
`ifdef WFQ_WEIGHT_EN
        ,
        .weight     (weight)
`endif
    );

    // upstream FIFO contents
    logic [DW-1:0] mem [N][DEPTH];
    int  rd_p [N];
    int  cnt  [N];
    bit  blocked [N];
    int  wt [N];

    // reference scheduler state
    bit  m_send;
    int  m_vt, m_cur, m_tag, m_rem;
    int  m_lf [N];
    int  words_seen, pkts_done;
    int  order [$];

    int  checks = 0;
    int  errors = 0;

    typedef struct {
        int ch;
        int lenf;
        int ready_pct;
        int exp_words;
    } vec_t;

    function automatic bit vis(int ch);
        return cnt[ch] > 0 && !blocked[ch];
    endfunction

    function automatic int vmod(int x);
        return x & ((1 << VW) - 1);
    endfunction

    function automatic bit vlt(int a, int b);
        return vmod(a - b) >= (1 << (VW - 1));
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(int ch, int lenf);
        int n;
        logic [DW-1:0] w;
        n = (lenf == 0) ? 1 : lenf;
        for (int k = 0; k < n; k++) begin
            w = $urandom;
            if (k == 0) w[LW-1:0] = lenf[LW-1:0];
            mem[ch][(rd_p[ch] + cnt[ch]) % DEPTH] = w;
            cnt[ch]++;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            fifo_empty[i]        = !vis(i);
            fifo_data[i*DW +: DW] = (cnt[i] > 0) ? mem[i][rd_p[i]] : DW'($urandom);
`ifdef WFQ_WEIGHT_EN
            weight[i*4 +: 4] = 4'(wt[i]);
`endif
        end
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < N; i++) begin
            cnt[i]     = 0;
            rd_p[i]    = 0;
            blocked[i] = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_send = 1'b0;
        m_vt   = 0;
        m_cur  = 0;
        m_tag  = 0;
        m_rem  = 0;
        for (int i = 0; i < N; i++) m_lf[i] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_fifos();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One cycle: entered just after a rising edge, leaves just after the next one.
    task automatic step();
        bit ev, xfer, found;
        int best, bt, ln, c, bs, f;
        xfer  = 1'b0;
        found = 1'b0;
        best  = 0;
        bt    = 0;
        drive();
        @(negedge clk);
        if (!m_send) begin
            chk("idle_valid", out_valid, 0);
            chk("idle_last", out_last, 0);
            chk("idle_rdreq", fifo_rdreq, 0);
            chk("idle_chan", out_chan, 0);
            chk("idle_data", out_data, 0);
            for (int i = 0; i < N; i++) begin
                if (vis(i)) begin
                    ln = int'(mem[i][rd_p[i]][LW-1:0]);
                    if (ln == 0) ln = 1;
`ifdef WFQ_WEIGHT_EN
                    c = wt[i] & 15;
                    if (c == 0) c = 1;
`else
                    c = 1;
`endif
                    bs = vlt(m_vt, m_lf[i]) ? m_lf[i] : m_vt;
                    f  = vmod(bs + ln * c);
                    if (!found || vlt(f, bt)) begin
                        found = 1'b1;
                        best  = i;
                        bt    = f;
                    end
                end
            end
        end else begin
            ev = vis(m_cur);
            chk("valid", out_valid, ev);
            if (ev) begin
                chk("data", out_data, mem[m_cur][rd_p[m_cur]]);
                chk("last", out_last, m_rem == 1);
                chk("chan", out_chan, m_cur);
            end
            xfer = ev && out_ready;
            chk("rdreq", fifo_rdreq, xfer ? (1 << m_cur) : 0);
        end
        @(posedge clk);
        #1;
        if (found) begin
            m_send = 1'b1;
            m_cur  = best;
            m_tag  = bt;
            ln     = int'(mem[best][rd_p[best]][LW-1:0]);
            m_rem  = (ln == 0) ? 1 : ln;
            order.push_back(best);
        end else if (xfer) begin
            rd_p[m_cur] = (rd_p[m_cur] + 1) % DEPTH;
            cnt[m_cur]--;
            words_seen++;
            m_rem--;
            m_vt = vmod(m_vt + 1);
            if (m_rem == 0) begin
                m_lf[m_cur] = m_tag;
                m_send      = 1'b0;
                pkts_done++;
            end
        end
    endtask

    task automatic check_state(string name);
        chk({name, "_vtime"}, dut.vtime_q, m_vt);
        for (int i = 0; i < N; i++) chk({name, "_lf"}, dut.last_finish_q[i], m_lf[i]);
    endtask

    task automatic run_pkts(int target, int budget);
        int start, c;
        start = pkts_done;
        c = 0;
        while (pkts_done - start < target && c < budget) begin
            step();
            c++;
        end
        chk("pkt_budget", pkts_done - start, target);
    endtask

    task automatic run_words(int target, int budget);
        int start, c;
        start = words_seen;
        c = 0;
        while (words_seen - start < target && c < budget) begin
            step();
            c++;
        end
        chk("word_budget", words_seen - start, target);
    endtask

    initial begin
        vec_t vecs [5];
        int   w0, c;
        vecs[0] = '{ch: 2, lenf: 3,  ready_pct: 100, exp_words: 3};
        vecs[1] = '{ch: 0, lenf: 1,  ready_pct: 100, exp_words: 1};
        vecs[2] = '{ch: 3, lenf: 0,  ready_pct: 100, exp_words: 1};
        vecs[3] = '{ch: 1, lenf: 15, ready_pct: 60,  exp_words: 15};
        vecs[4] = '{ch: 2, lenf: 6,  ready_pct: 30,  exp_words: 6};
        for (int i = 0; i < N; i++) wt[i] = 1;
        words_seen = 0;
        pkts_done  = 0;

        // reset state
        do_reset();
        repeat (2) step();
        check_state("reset");

        // single packets from the table
        for (int v = 0; v < 5; v++) begin
            do_reset();
            push_pkt(vecs[v].ch, vecs[v].lenf);
            w0 = words_seen;
            c  = 0;
            while (pkts_done == 0 || cnt[vecs[v].ch] > 0 || m_send) begin
                if (c > 200) break;
                out_ready = ($urandom_range(99) < vecs[v].ready_pct);
                step();
                c++;
                if (!m_send && cnt[vecs[v].ch] == 0) break;
            end
            chk("vec_words", words_seen - w0, vecs[v].exp_words);
            chk("vec_vtime", dut.vtime_q, vecs[v].exp_words);
            chk("vec_lf", dut.last_finish_q[vecs[v].ch], vecs[v].exp_words);
            chk("vec_chan", order[order.size() - 1], vecs[v].ch);
            step();
        end

        // two packets each on ch0 and ch1, ready from reset
        do_reset();
        out_ready = 1'b1;
        push_pkt(0, 4);
        push_pkt(0, 4);
        push_pkt(1, 4);
        push_pkt(1, 4);
        run_pkts(4, 60);
        check_state("tie");

        // backpressure then underrun on ch0
        do_reset();
        out_ready = 1'b1;
        push_pkt(0, 5);
        w0 = words_seen;
        run_words(1, 10);
        out_ready = 1'b0;
        repeat (2) step();
        chk("bp_nopop", words_seen - w0, 1);
        out_ready = 1'b1;
        run_words(2, 10);
        blocked[0] = 1'b1;
        repeat (3) step();
        chk("underrun_hold", words_seen - w0, 3);
        blocked[0] = 1'b0;
        run_pkts(1, 20);
        chk("bp_total", words_seen - w0, 5);

        // reset during word 2 of a 4-word packet
        do_reset();
        out_ready = 1'b1;
        push_pkt(1, 4);
        run_words(1, 10);
        rst = 1'b1;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_fifos();
        model_reset();
        drive();
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_rdreq", fifo_rdreq, 0);
        chk("rst_vtime", dut.vtime_q, 0);
        @(posedge clk);
        #1;
        repeat (2) step();

        // weighted backlog on ch0/ch1
        do_reset();
        out_ready = 1'b1;
        wt[0] = 1;
        wt[1] = 2;
        c = 0;
        while (pkts_done < 1000000 && c < 300) begin
            if (cnt[0] < 12) push_pkt(0, 4);
            if (cnt[1] < 12) push_pkt(1, 4);
            step();
            c++;
        end
        check_state("weight");
        for (int i = 0; i < N; i++) wt[i] = 1;

        // long saturation across the vtime wrap
        do_reset();
        out_ready = 1'b1;
        w0 = pkts_done;
        c  = 0;
        while (pkts_done - w0 < 80 && c < 1500) begin
            if (cnt[0] < 14) push_pkt(0, 7);
            if (cnt[1] < 14) push_pkt(1, 7);
            step();
            c++;
        end
        chk("wrap_pkts", pkts_done - w0, 80);
        check_state("wrap");

        // random traffic
        do_reset();
        for (int i = 0; i < N; i++) wt[i] = $urandom_range(3);
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (cnt[i] < 30 && $urandom_range(9) == 0) push_pkt(i, $urandom_range(6));
                blocked[i] = ($urandom_range(9) == 0);
            end
            out_ready = ($urandom_range(3) != 0);
            step();
        end
        for (int i = 0; i < N; i++) blocked[i] = 1'b0;
        out_ready = 1'b1;
        c = 0;
        while ((m_send || cnt[0] + cnt[1] + cnt[2] + cnt[3] > 0) && c < 2000) begin
            step();
            c++;
        end
        chk("drained", cnt[0] + cnt[1] + cnt[2] + cnt[3], 0);
        check_state("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
